mem_stage: RTL and testbench

MEM stage of the 5-stage RV32 pipeline. It is the consumer of the EX/MEM register outputs.
- Resolves branches and jumps, producing pcsrc and the redirect target. pcsrc is also the flush input of the EX/MEM register.
- Drives a req/ack data-memory bus with byte-lane alignment.
- Stalls upstream while a memory access is outstanding.
- Owns the MEM/WB pipeline register.

---
 rtl/mem_stage_pkg.sv | 39 +++
 rtl/mem_stage_if.sv | 24 ++
 rtl/mem_lsu_align.sv | 67 ++++++
 rtl/mem_stage.sv | 162 ++++++++++++++++
 tb/tb_mem_stage.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared func3 codes, FSM state and MEM/WB bubble for the MEM stage
// Contents: branch/load/store func3 constants, state_e, wb_ctrl_t and its bubble value.
package mem_stage_pkg;

  // Branch subtypes
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // Load subtypes
  localparam logic [2:0] LB   = 3'b000;
  localparam logic [2:0] LH   = 3'b001;
  localparam logic [2:0] LW   = 3'b010;
  localparam logic [2:0] LBU  = 3'b100;
  localparam logic [2:0] LHU  = 3'b101;

  // Store subtypes
  localparam logic [2:0] SB   = 3'b000;
  localparam logic [2:0] SH   = 3'b001;
  localparam logic [2:0] SW   = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Control half of the MEM/WB register; data fields are cleared alongside it.
  typedef struct packed {
    logic [4:0] rd;
    logic       memtoreg;
    logic       regwrite;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_CTRL_BUBBLE = '{rd: 5'd0, memtoreg: 1'b0, regwrite: 1'b0};

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - req/ack data-memory bus between the MEM stage and data memory
// master: req, we, addr (word aligned), wdata, be out; rdata, ack in.
// slave : the mirror image, for the memory model.
interface mem_stage_if #(
  parameter int XLEN = 32
);
  logic            req;
  logic            we;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wdata;
  logic [3:0]      be;
  logic [XLEN-1:0] rdata;
  logic            ack;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack
  );
endinterface

// File: rtl/mem_lsu_align.sv
// rtl/mem_lsu_align.sv - byte-lane alignment: store be/wdata, load extract/extend, misalignment
// Inputs : func3, addr_lo (address bits 1:0), is_store, store_data, load_word.
// Outputs: be, wdata, load_data, misaligned.
module mem_lsu_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      func3,
  input  logic [1:0]      addr_lo,
  input  logic            is_store,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_word,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);

  logic [XLEN-1:0] shifted;

  // Load and store func3 share the size encoding in bits 1:0 (00 byte, 01 half, 10 word).
  always_comb begin
    misaligned = 1'b0;
    case (func3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = (addr_lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    be    = 4'b1111;
    wdata = store_data;
    if (is_store) begin
      case (func3)
        SB: begin
          be    = 4'b0001 << addr_lo;
          wdata = {(XLEN/8){store_data[7:0]}};
        end
        SH: begin
          be    = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata = {(XLEN/16){store_data[15:0]}};
        end
        default: begin
          be    = 4'b1111;
          wdata = store_data;
        end
      endcase
    end
  end

  // Bring the addressed byte/half down to bit 0; halves are aligned so the shift is 0 or 16.
  assign shifted = load_word >> {addr_lo, 3'b000};

  always_comb begin
    load_data = load_word;
    case (func3)
      LB:      load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LH:      load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LBU:     load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LHU:     load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32 MEM stage: branch resolve, data-memory access, MEM/WB register
// Inputs : clk, rst, EX/MEM fields (*_ex), dmem bus slave side via dmem.rdata/dmem.ack.
// Outputs: pcsrc, pc_target, stall, dmem bus (req/we/addr/wdata/be), MEM/WB fields (*_wb),
//          misalign_err and bus_err one-cycle pulses.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] sumB_ex,
  input  logic            zero_ex,
  input  logic [XLEN-1:0] alures_ex,
  input  logic [XLEN-1:0] b_ex,
  input  logic [4:0]      rd_ex,
  input  logic            branch_ex,
  input  logic            jump_ex,
  input  logic            memread_ex,
  input  logic            memwrite_ex,
  input  logic            memtoreg_ex,
  input  logic            regwrite_ex,
  input  logic [2:0]      func3_ex,
  output logic            pcsrc,
  output logic [XLEN-1:0] pc_target,
  output logic            stall,
  mem_stage_if.master     dmem,
  output logic [XLEN-1:0] memdata_wb,
  output logic [XLEN-1:0] alures_wb,
  output logic [4:0]      rd_wb,
  output logic            memtoreg_wb,
  output logic            regwrite_wb,
  output logic            misalign_err,
  output logic            bus_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] memdata_q, memdata_d;
  logic [XLEN-1:0] alures_q, alures_d;
  wb_ctrl_t        wb_ctrl_q, wb_ctrl_d;
  logic            misalign_err_q, misalign_err_d;
  logic            bus_err_q, bus_err_d;

  logic            is_mem, misaligned, access, timeout_abort, taken, wb_bubble;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata, load_data;

  mem_lsu_align #(.XLEN(XLEN)) u_align (
    .func3      (func3_ex),
    .addr_lo    (alures_ex[1:0]),
    .is_store   (memwrite_ex),
    .store_data (b_ex),
    .load_word  (dmem.rdata),
    .be         (st_be),
    .wdata      (st_wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  assign is_mem = memread_ex | memwrite_ex;
  assign access = is_mem & ~misaligned;

  // Give up once TIMEOUT cycles have been spent waiting; an ack in that same cycle still wins.
  assign timeout_abort = (TIMEOUT != 0) && (state_q == WAIT) && (cnt_q == CW'(TIMEOUT))
                         && !dmem.ack && access;

  // A request is live in both states, so req only depends on access (and reset).
  assign dmem.req   = access & ~rst;
  assign dmem.we    = memwrite_ex;
  assign dmem.addr  = {alures_ex[XLEN-1:2], 2'b00};
  assign dmem.wdata = st_wdata;
  assign dmem.be    = st_be;

  assign stall = access & ~dmem.ack & ~timeout_abort & ~rst;

  always_comb begin
    taken = 1'b0;
    case (func3_ex)
      BEQ:         taken = zero_ex;
      BNE:         taken = ~zero_ex;
      BLT, BLTU:   taken = alures_ex[0];
      BGE, BGEU:   taken = ~alures_ex[0];
      default:     taken = 1'b0;
    endcase
  end

  assign pcsrc     = ((branch_ex & taken) | jump_ex) & ~stall & ~rst;
  assign pc_target = sumB_ex;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (access && !dmem.ack) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (dmem.ack || timeout_abort || !access) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign wb_bubble = stall | (is_mem & misaligned) | timeout_abort;

  always_comb begin
    memdata_d      = load_data;
    alures_d       = alures_ex;
    wb_ctrl_d      = '{rd: rd_ex, memtoreg: memtoreg_ex, regwrite: regwrite_ex};
    misalign_err_d = is_mem & misaligned;
    bus_err_d      = timeout_abort;
    if (wb_bubble) begin
      memdata_d = '0;
      alures_d  = '0;
      wb_ctrl_d = WB_CTRL_BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      memdata_q      <= '0;
      alures_q       <= '0;
      wb_ctrl_q      <= WB_CTRL_BUBBLE;
      misalign_err_q <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      memdata_q      <= memdata_d;
      alures_q       <= alures_d;
      wb_ctrl_q      <= wb_ctrl_d;
      misalign_err_q <= misalign_err_d;
      bus_err_q      <= bus_err_d;
    end
  end

  assign memdata_wb   = memdata_q;
  assign alures_wb    = alures_q;
  assign rd_wb        = wb_ctrl_q.rd;
  assign memtoreg_wb  = wb_ctrl_q.memtoreg;
  assign regwrite_wb  = wb_ctrl_q.regwrite;
  assign misalign_err = misalign_err_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a behavioural model
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] sumb, alures, bdat, rdata_tb;
  logic        zero, br, jmp, mr, mw, m2r, rw, ack_tb;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic        pcsrc, stall, misalign_err, bus_err, memtoreg_wb, regwrite_wb;
  logic [31:0] pc_target, memdata_wb, alures_wb;
  logic [4:0]  rd_wb;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] lds [5] = '{LB, LH, LW, LBU, LHU};

  mem_stage_if #(.XLEN(32)) dmem ();
  assign dmem.rdata = rdata_tb;
  assign dmem.ack   = ack_tb;

  mem_stage #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .sumB_ex(sumb), .zero_ex(zero), .alures_ex(alures), .b_ex(bdat),
    .rd_ex(rd), .branch_ex(br), .jump_ex(jmp), .memread_ex(mr), .memwrite_ex(mw),
    .memtoreg_ex(m2r), .regwrite_ex(rw), .func3_ex(f3), .pcsrc(pcsrc), .pc_target(pc_target),
    .stall(stall), .dmem(dmem), .memdata_wb(memdata_wb), .alures_wb(alures_wb), .rd_wb(rd_wb),
    .memtoreg_wb(memtoreg_wb), .regwrite_wb(regwrite_wb), .misalign_err(misalign_err),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Access size in bytes for the operation as the ISA defines it.
  function automatic int acc_size(input logic wr, input logic [2:0] f);
    if (wr) return (f == SB) ? 1 : (f == SH) ? 2 : 4;
    return (f == LB || f == LBU) ? 1 : (f == LH || f == LHU) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f, input logic [31:0] w, input int off);
    int sz = acc_size(1'b0, f);
    logic [31:0] mask;
    logic [31:0] v;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v = (w >> (8 * off)) & mask;
    if ((f == LB || f == LH) && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic is_taken(input logic [2:0] f, input logic z, input logic slt);
    case (f)
      3'd0: return z;
      3'd1: return !z;
      3'd4, 3'd6: return slt;
      3'd5, 3'd7: return !slt;
      default: return 1'b0;
    endcase
  endfunction

  task automatic clr();
    sumb = 0; alures = 0; bdat = 0; rdata_tb = 0; zero = 0; br = 0; jmp = 0;
    mr = 0; mw = 0; m2r = 0; rw = 0; ack_tb = 0; rd = 0; f3 = 0;
  endtask

  // Present the current EX/MEM fields, ack after lat cycles (lat > TO: never), check every cycle.
  task automatic run_op(input int lat);
    logic is_mem, misal, access, abort, exp_stall, bubble;
    int sz, off, stall_n;
    logic [31:0] exp_be, exp_wd;
    is_mem = mr | mw;
    sz     = acc_size(mw, f3);
    off    = int'(alures[1:0]);
    misal  = is_mem && ((off % sz) != 0);
    access = is_mem && !misal;
    abort  = 1'b0;
    if (!access) stall_n = 0;
    else if (lat <= TO) stall_n = lat;
    else begin stall_n = TO; abort = 1'b1; end
    exp_be = (sz == 1) ? (32'd1 << off) : (sz == 2) ? (32'd3 << off) : 32'hF;
    exp_wd = (sz == 1) ? 32'(bdat[7:0]) * 32'h0101_0101 :
             (sz == 2) ? 32'(bdat[15:0]) * 32'h0001_0001 : bdat;
    for (int c = 0; c <= stall_n; c++) begin
      ack_tb = access ? (c == lat) : 1'($urandom_range(0, 1));
      #1;
      exp_stall = (c < stall_n);
      chk("stall", stall, exp_stall);
      chk("dmem_req", dmem.req, access);
      chk("pcsrc", pcsrc, ((br && is_taken(f3, zero, alures[0])) || jmp) && !exp_stall);
      chk("pc_target", pc_target, sumb);
      if (access) begin
        chk("dmem_addr", dmem.addr, alures & 32'hFFFF_FFFC);
        chk("dmem_we", dmem.we, mw);
        chk("dmem_be", dmem.be, mw ? exp_be : 32'hF);
        if (mw) chk("dmem_wdata", dmem.wdata, exp_wd);
      end
      @(posedge clk);
      @(negedge clk);
      bubble = exp_stall || misal || (abort && c == stall_n);
      chk("regwrite_wb", regwrite_wb, bubble ? 1'b0 : rw);
      chk("memtoreg_wb", memtoreg_wb, bubble ? 1'b0 : m2r);
      chk("rd_wb", rd_wb, bubble ? 5'd0 : rd);
      chk("alures_wb", alures_wb, bubble ? 32'd0 : alures);
      if (bubble) chk("memdata_wb", memdata_wb, 32'd0);
      else if (mr && !mw) chk("memdata_wb", memdata_wb, load_val(f3, rdata_tb, off));
      chk("misalign_err", misalign_err, misal && (c == stall_n));
      chk("bus_err", bus_err, abort && (c == stall_n));
    end
    ack_tb = 1'b0;
  endtask

  task automatic rand_op();
    int k;
    clr();
    k        = $urandom_range(0, 9);
    sumb     = $urandom;
    alures   = $urandom;
    bdat     = $urandom;
    rdata_tb = $urandom;
    zero     = 1'($urandom_range(0, 1));
    rd       = 5'($urandom_range(0, 31));
    m2r      = 1'($urandom_range(0, 1));
    rw       = 1'($urandom_range(0, 1));
    f3       = 3'($urandom_range(0, 7));
    br       = 1'($urandom_range(0, 1));
    jmp      = ($urandom_range(0, 3) == 0);
    if (k < 3) begin mr = 1; f3 = lds[$urandom_range(0, 4)]; end
    else if (k < 5) begin mw = 1; f3 = 3'($urandom_range(0, 2)); end
    else if (k == 5) begin mr = 1; mw = 1; f3 = 3'($urandom_range(0, 2)); end
    if ($urandom_range(0, 1) == 1) alures[1:0] = 2'b00;
  endtask

  initial begin
    clr();
    rst = 1'b1;
    mr = 1; f3 = LW; alures = 32'h100; jmp = 1;
    @(negedge clk);
    #1;
    chk("rst_req", dmem.req, 1'b0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_pcsrc", pcsrc, 1'b0);
    @(negedge clk);
    chk("rst_regwrite_wb", regwrite_wb, 1'b0);
    chk("rst_memdata_wb", memdata_wb, 32'd0);
    chk("rst_misalign_err", misalign_err, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    rst = 1'b0;
    clr();

    // LW zero-wait
    mr = 1; m2r = 1; rw = 1; rd = 5'd3; f3 = LW; alures = 32'h100; rdata_tb = 32'hDEAD_BEEF;
    run_op(0);
    chk("lw_data", memdata_wb, 32'hDEAD_BEEF);
    // LB three-cycle wait
    clr(); mr = 1; m2r = 1; rw = 1; rd = 5'd4; f3 = LB; alures = 32'h103; rdata_tb = 32'h80FF_FFFF;
    run_op(3);
    chk("lb_data", memdata_wb, 32'hFFFF_FF80);
    // SH upper half
    clr(); mw = 1; f3 = SH; alures = 32'h102; bdat = 32'h1234_ABCD;
    run_op(1);
    // SW misaligned
    clr(); mw = 1; f3 = SW; alures = 32'h101; rw = 1; rd = 5'd9;
    run_op(0);
    // Branches and jump
    clr(); br = 1; f3 = BNE; zero = 0; sumb = 32'h0000_4000;
    run_op(0);
    clr(); br = 1; f3 = BGE; alures = 32'h1;
    run_op(0);
    clr(); jmp = 1; sumb = 32'h0000_0800;
    run_op(0);
    // LW never acked: timeout abort
    clr(); mr = 1; m2r = 1; rw = 1; rd = 5'd5; f3 = LW; alures = 32'h200;
    run_op(TO + 3);

    // Reset while waiting
    clr(); mr = 1; m2r = 1; rw = 1; rd = 5'd6; f3 = LW; alures = 32'h300;
    #1;
    chk("wait_stall0", stall, 1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("wait_stall2", stall, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstw_req", dmem.req, 1'b0);
    chk("rstw_stall", stall, 1'b0);
    @(negedge clk);
    chk("rstw_regwrite_wb", regwrite_wb, 1'b0);
    chk("rstw_rd_wb", rd_wb, 5'd0);
    chk("rstw_alures_wb", alures_wb, 32'd0);
    chk("rstw_bus_err", bus_err, 1'b0);
    rst = 1'b0;
    // Late ack with no access is ignored
    clr(); rw = 1; rd = 5'd7; alures = 32'h55;
    run_op(0);
    chk("late_ack_rd_wb", rd_wb, 5'd7);

    for (int i = 0; i < 400; i++) begin
      rand_op();
      run_op($urandom_range(0, TO + 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
